bcd_result_formatter: RTL and testbench
=======================================

Name: bcd_result_formatter

Overview:
- Sequential signed-binary to BCD converter feeding the seven-segment display driver. It produces the ones, tens, hundreds and sign fields the driver consumes.
- Takes a signed two's-complement calculator result, converts the magnitude by iterative shift-add-3 (double dabble), and presents registered digits with a start/done handshake.
- Digit outputs change only on completion, so the display never shows intermediate conversion values.

Parameters:
- W, 11, width of signed input value; legal range 4..14, because the internal BCD register holds 4 digits.
- MAX_MAG, 999, largest magnitude representable on three digits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request conversion of value; accepted only when busy=0
- value  in  W  signed two's-complement result
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; digit outputs valid and updated
- ones  out  4  BCD units digit
- tens  out  4  BCD tens digit
- hundreds  out  4  BCD hundreds digit
- sign  out  5  5'd0 = plus, 5'd1 = minus (display sign code)
- ovf  out  1  last converted magnitude exceeded MAX_MAG; held until the next done

Behaviour:
- Reset (reset=0 at posedge clk):
  - state IDLE; busy=0, done=0, ovf=0.
  - ones=tens=hundreds=0, sign=5'd0.
  - Shift counter and BCD register cleared.
  - Applies mid-conversion too: the conversion is aborted and no done is produced.
- States: IDLE, CONV, DONE.
- IDLE:
  - On start=1, latch neg=value[W-1] and mag=|value| as a W-bit unsigned value. -2^(W-1) yields 2^(W-1) with no wrap.
  - Latch big=(mag>MAX_MAG).
  - Clear the 16-bit BCD register, set the counter to 0, go to CONV.
- CONV, one iteration per clock:
  - Each BCD nibble >=5 gets +3.
  - Then {bcd,mag} shifts left by 1.
  - Counter increments; after W iterations go to DONE.
- DONE, one cycle:
  - done=1.
  - If big and saturation is enabled (see Optional Feature), output digits 9,9,9. Otherwise output the low three BCD digits (value mod 1000).
  - sign=neg ? 5'd1 : 5'd0; ovf=big.
  - Next state IDLE.
- Latency: start sampled at edge k -> done high during the cycle after edge k+W+1, i.e. W+1 clocks; 12 for W=11.
- busy is high in CONV only. start is accepted in IDLE and also during the DONE cycle (back-to-back), in which case the next state is CONV. start while in CONV is ignored and not queued.
- value is sampled only at acceptance; later changes have no effect.
- Zero input: digits 0,0,0, sign plus. Negative zero is impossible in two's complement.
- Digit outputs, sign and ovf hold between done pulses.

Optional Feature:
- Macro BCD_SATURATE_EN.
- Defined: magnitude > MAX_MAG displays 9,9,9 with the original sign; ovf=1.
- Undefined: digits are magnitude mod 1000 (low three BCD digits); ovf=1 still reported.

Decomposition:
- Shared package calc_pkg holds:
  - state enum typedef (IDLE/CONV/DONE)
  - DIGIT_W=4
  - SIGN_PLUS=5'd0, SIGN_MINUS=5'd1
  - BCD_NINE=4'd9
- One natural combinational sub-module: bcd_adjust_digit. It takes a 4-bit nibble and returns nibble+3 if >=5, else the unchanged nibble. It is instantiated 4 times.

Test Plan:
- Reset then value=+123, start 1 cycle -> busy for 11 cycles, done after 12 clocks; ones=3, tens=2, hundreds=1, sign=0, ovf=0.
- value=-45 -> ones=5, tens=4, hundreds=0, sign=5'd1, ovf=0; value=0 -> 0,0,0, sign=0.
- value=1023:
  - with BCD_SATURATE_EN -> 9,9,9, sign=0, ovf=1
  - without -> ones=3, tens=2, hundreds=0, ovf=1
- value=-1024 (most negative) -> ovf=1, sign=5'd1; saturated 9,9,9 or mod-1000 0,2,4 per macro.
- start pulsed mid-CONV with a different value -> ignored; first result reported. start asserted in the DONE cycle -> second conversion runs back-to-back, done 12 clocks later.
- reset=0 at cycle 5 of a conversion -> no done; outputs 0/plus/ovf=0 next cycle; subsequent start converts normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int              DIGIT_W    = 4;
  localparam logic [4:0]      SIGN_PLUS  = 5'd0;
  localparam logic [4:0]      SIGN_MINUS = 5'd1;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_adjust_digit.sv
// One double-dabble correction step: add 3 to a BCD nibble that is 5 or more.
module bcd_adjust_digit
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bcd_result_formatter.sv
// Sequential signed-binary to BCD converter (double dabble) with start/done handshake.
// Define BCD_SATURATE_EN to show 9,9,9 for magnitudes above MAX_MAG.
module bcd_result_formatter
  import calc_pkg::*;
#(
  parameter int W       = 11,
  parameter int MAX_MAG = 999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [W-1:0]       value,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] hundreds,
  output logic [4:0]         sign,
  output logic               ovf
);

  localparam int BCD_W = 4 * DIGIT_W;
  localparam int CNT_W = $clog2(W + 1);

  state_t           state, state_next;
  logic [W-1:0]     mag;
  logic [W-1:0]     abs_value;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             big;
  logic             accept;

  // Two's-complement negate in W bits: the most negative value maps to 2^(W-1) unsigned.
  assign abs_value = value[W-1] ? (~value + W'(1)) : value;
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == CONV);

  for (genvar d = 0; d < 4; d++) begin : g_adj
    bcd_adjust_digit u_adj (
      .nibble  (bcd[d*DIGIT_W +: DIGIT_W]),
      .adjusted(bcd_adj[d*DIGIT_W +: DIGIT_W])
    );
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt == CNT_W'(W - 1)) state_next = DONE;
      DONE:    state_next = start ? CONV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      big      <= 1'b0;
      done     <= 1'b0;
      ones     <= '0;
      tens     <= '0;
      hundreds <= '0;
      sign     <= SIGN_PLUS;
      ovf      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;

      if (accept) begin
        neg <= value[W-1];
        mag <= abs_value;
        big <= int'(abs_value) > MAX_MAG;
        bcd <= '0;
        cnt <= '0;
      end else if (state == CONV) begin
        {bcd, mag} <= {bcd_adj, mag} << 1;
        cnt        <= cnt + CNT_W'(1);
      end

      // Results publish from the previous conversion's neg/big even when a new start lands here.
      if (state == DONE) begin
        done <= 1'b1;
        sign <= neg ? SIGN_MINUS : SIGN_PLUS;
        ovf  <= big;
`ifdef BCD_SATURATE_EN
        if (big) begin
          ones     <= BCD_NINE;
          tens     <= BCD_NINE;
          hundreds <= BCD_NINE;
        end else begin
          ones     <= bcd[0*DIGIT_W +: DIGIT_W];
          tens     <= bcd[1*DIGIT_W +: DIGIT_W];
          hundreds <= bcd[2*DIGIT_W +: DIGIT_W];
        end
`else
        ones     <= bcd[0*DIGIT_W +: DIGIT_W];
        tens     <= bcd[1*DIGIT_W +: DIGIT_W];
        hundreds <= bcd[2*DIGIT_W +: DIGIT_W];
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_result_formatter.sv
// Scoreboard bench for bcd_result_formatter: expected digits queued at start, checked on done.
module tb_bcd_result_formatter;
  import calc_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] value = '0;
  logic         busy, done, ovf;
  logic [3:0]   ones, tens, hundreds;
  logic [4:0]   sign;

  typedef struct packed {
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [4:0] sign;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  bcd_result_formatter #(.W(W), .MAX_MAG(999)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .ones    (ones),
    .tens    (tens),
    .hundreds(hundreds),
    .sign    (sign),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && done === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_done: got %0d%0d%0d sign=%0d ovf=%0b, no result pending",
                 hundreds, tens, ones, sign, ovf);
      end else begin
        mon_exp = sb.pop_front();
        if ({ones, tens, hundreds, sign, ovf} !== mon_exp) begin
          $display("FAIL result: got h/t/o=%0d/%0d/%0d sign=%0d ovf=%0b, want %0d/%0d/%0d sign=%0d ovf=%0b",
                   hundreds, tens, ones, sign, ovf, mon_exp.hundreds, mon_exp.tens,
                   mon_exp.ones, mon_exp.sign, mon_exp.ovf);
        end else begin
          n_pass++;
        end
      end
    end
  end

  function automatic exp_t model(input int v);
    exp_t e;
    int   mag;
    int   m;
    mag   = (v < 0) ? -v : v;
    e.ovf = (mag > 999);
    e.sign = (v < 0) ? 5'd1 : 5'd0;
`ifdef BCD_SATURATE_EN
    m = e.ovf ? 999 : mag % 1000;
`else
    m = mag % 1000;
`endif
    e.ones     = 4'(m % 10);
    e.tens     = 4'((m / 10) % 10);
    e.hundreds = 4'(m / 100);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; value is scrambled afterwards to prove it is sampled only once.
  task automatic start_conv(input int v, output exp_t e);
    e     = model(v);
    value = W'(v);
    start = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    value = W'($urandom);
  endtask

  task automatic wait_result(input string name, input exp_t e, output int lat, output int busy_n);
    bit seen;
    seen   = 1'b0;
    lat    = 0;
    busy_n = busy ? 1 : 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (busy) begin
        busy_n++;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL %s_timeout: no done within 40 cycles", name);
    else n_pass++;
    if (seen) begin
      tick();
      n_checks++;
      if ({done, ones, tens, hundreds, sign, ovf} !== {1'b0, e}) begin
        $display("FAIL %s_hold: got done=%0b h/t/o=%0d/%0d/%0d sign=%0d ovf=%0b, want done=0 %0d/%0d/%0d sign=%0d ovf=%0b",
                 name, done, hundreds, tens, ones, sign, ovf, e.hundreds, e.tens, e.ones, e.sign, e.ovf);
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, done, ovf, ones, tens, hundreds, sign} !== '0)
      $display("FAIL reset_state: got busy=%0b done=%0b ovf=%0b h/t/o=%0d/%0d/%0d sign=%0d, want all 0",
               busy, done, ovf, hundreds, tens, ones, sign);
    else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic run_one(input string name, input int v);
    exp_t e;
    int   lat, bn;
    start_conv(v, e);
    wait_result(name, e, lat, bn);
    n_checks++;
    if (lat !== 12) $display("FAIL %s_latency: got %0d clocks, want 12", name, lat);
    else n_pass++;
    n_checks++;
    if (bn !== 11) $display("FAIL %s_busy: got %0d busy cycles, want 11", name, bn);
    else n_pass++;
  endtask

  task automatic test_basic;
    run_one("pos123", 123);
    run_one("neg45", -45);
    run_one("zero", 0);
    run_one("max999", 999);
  endtask

  task automatic test_overflow;
    run_one("ovf1023", 1023);
    run_one("ovf_min", -1024);
    run_one("ovf_neg1000", -1000);
  endtask

  task automatic test_start_ignored;
    exp_t e;
    int   lat, bn, extra;
    start_conv(77, e);
    repeat (3) tick();
    start = 1'b1;
    value = W'(555);
    tick();
    start = 1'b0;
    wait_result("ignored", e, lat, bn);
    n_checks++;
    if (lat !== 8) $display("FAIL ignored_latency: got %0d, want 8", lat);
    else n_pass++;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL ignored_queued: got %0d busy/done cycles, want 0", extra);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    exp_t a, b;
    int   lat, bn, guard;
    start_conv(456, a);
    guard = 0;
    while (busy && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (busy || done) $display("FAIL b2b_done_state: got busy=%0b done=%0b, want 0/0", busy, done);
    else n_pass++;
    b     = model(-789);
    value = W'(-789);
    start = 1'b1;
    sb.push_back(b);
    tick();
    start = 1'b0;
    value = W'($urandom);
    n_checks++;
    if (done !== 1'b1) $display("FAIL b2b_first_done: got %0b, want 1", done);
    else n_pass++;
    wait_result("b2b", b, lat, bn);
    n_checks++;
    if (lat !== 12) $display("FAIL b2b_latency: got %0d, want 12", lat);
    else n_pass++;
    n_checks++;
    if (bn !== 11) $display("FAIL b2b_busy: got %0d, want 11", bn);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   extra;
    start_conv(321, e);
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
    n_checks++;
    if ({busy, done, ovf, ones, tens, hundreds, sign} !== '0)
      $display("FAIL midreset_state: got busy=%0b done=%0b ovf=%0b h/t/o=%0d/%0d/%0d sign=%0d, want all 0",
               busy, done, ovf, hundreds, tens, ones, sign);
    else n_pass++;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL midreset_done: got %0d busy/done cycles, want 0", extra);
    else n_pass++;
    run_one("after_reset", 9);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    run_one("pre_reset_ovf", 1023);
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
